// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the transmit FSM state encoding and the line/parity encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; full and empty derive from the
// occupancy count, so the pointers themselves are allowed to wrap freely.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame FSM with runtime baud divider,
// optional parity and 1/2 stop bits; queued words go out back-to-back.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          stop2,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              IDX_W     = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_word;
  logic [DATA_W-1:0] shreg;
  logic [DIV_W-1:0]  timer;
  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  bit_idx;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              par_calc;
  logic              bit_done;
  logic              last_stop;

  assign data_ready = !fifo_full;
  assign fifo_push  = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign bit_done   = (timer == '0);
  assign last_stop  = (bit_idx == IDX_W'(stop2_q));

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (data),
    .pop       (fifo_pop),
    .pop_data  (fifo_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Parity is resolved once per frame, from the word as it leaves the FIFO
  always_comb begin
    par_calc = ^fifo_word;
    case (parity_type)
      PAR_EVEN: par_calc = ^fifo_word;
      PAR_ODD:  par_calc = ~^fifo_word;
    endcase
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    data_out  = LINE_IDLE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        data_out = ~LINE_IDLE;
        if (bit_done) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        data_out = shreg[0];
        if (bit_done && bit_idx == LAST_DATA) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        data_out = par_bit_q;
        if (bit_done) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when more words are queued
        if (bit_done && last_stop) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame config is captured at pop time so input changes never disturb a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      timer     <= '0;
      div_q     <= '0;
      bit_idx   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (fifo_pop) begin
      shreg     <= fifo_word;
      timer     <= baud_div;
      div_q     <= baud_div;
      bit_idx   <= '0;
      par_en_q  <= parity_en;
      par_bit_q <= par_calc;
      stop2_q   <= stop2;
    end else if (state != IDLE) begin
      if (bit_done) begin
        timer   <= div_q;
        bit_idx <= (state_nxt != state) ? '0 : bit_idx + IDX_W'(1);
        if (state == DATA) begin
          shreg <= shreg >> 1;
        end
      end else begin
        timer <= timer - DIV_W'(1);
      end
    end
  end

endmodule
